multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the 32-bit RV32I-subset core.
- Sequences fetch, decode, execute, memory and writeback for R, I-load, I-ALU, S and B opcodes.
- Drives datapath strobes (IR, PC, regfile, ALU, memory) and consumes the latched instruction and ALU zero flag.
- Sits beside the immediate generator, register file and ALU. It owns the memory handshake and flags illegal opcodes.

---
 rtl/multicycle_ctrl_if.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for multicycle_ctrl.
// With MULTICYCLE_CTRL_PERF_EN defined the bundle also carries the cycle/instret counters.
interface multicycle_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] instr;
  logic            alu_zero;
  logic            mem_ready;
  logic            mem_req;
  logic            mem_we;
  logic            mem_addr_sel;
  logic            ir_we;
  logic            pc_we;
  logic            pc_src;
  logic            alu_src_b;
  logic [1:0]      alu_op;
  logic            reg_we;
  logic            wb_sel;
  logic            instr_done;
  logic            illegal;
  logic [2:0]      state_dbg;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0]     cycle_cnt;
  logic [31:0]     instret_cnt;
`endif

  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
           alu_op, reg_we, wb_sel, instr_done, illegal, state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
    , output cycle_cnt, instret_cnt
`endif
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
           alu_op, reg_we, wb_sel, instr_done, illegal, state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
    , input cycle_cnt, instret_cnt
`endif
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core (fetch/decode/exec/mem/wb, trap on illegal).
// Optional perf counters (cycle_cnt, instret_cnt) are built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);
  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  funct3;
  logic             is_store;
  logic             taken;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign is_store = (opcode == OP_STORE);
  assign taken    = (funct3 == F3_BEQ) ? bus.alu_zero : !bus.alu_zero;

  // Register/immediate fields are consumed by the datapath, not here; no timeout logic exists.
  logic unused_bits;
  assign unused_bits = ^{bus.instr[XLEN-1:15], bus.instr[11:7], 32'(MEM_WAIT_MAX)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign bus.state_dbg = state_q;

  // Outputs are decoded from the current state; reset forces every strobe low.
  always_comb begin
    state_d          = state_q;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = 1'b0;
    bus.alu_src_b    = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = 1'b0;
    bus.instr_done   = 1'b0;
    bus.illegal      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
            state_d   = DECODE;
          end
        end
        DECODE: begin
          if (opcode == OP_R || opcode == OP_LOAD || opcode == OP_IALU ||
              opcode == OP_STORE || opcode == OP_BRANCH)
            state_d = EXEC;
          else
            state_d = TRAP;
        end
        EXEC: begin
          unique case (opcode)
            OP_R: begin
              bus.alu_op = ALU_FN;
              state_d    = WB;
            end
            OP_IALU: begin
              bus.alu_src_b = 1'b1;
              bus.alu_op    = ALU_FN;
              state_d       = WB;
            end
            OP_LOAD, OP_STORE: begin
              bus.alu_src_b = 1'b1;
              state_d       = MEM;
            end
            OP_BRANCH: begin
              bus.alu_op = ALU_SUB;
              if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                bus.pc_we      = taken;
                bus.pc_src     = taken;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
              end else begin
                state_d = TRAP;
              end
            end
            default: state_d = TRAP;
          endcase
        end
        MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = is_store;
          if (bus.mem_ready) begin
            bus.instr_done = is_store;
            state_d        = is_store ? FETCH : WB;
          end
        end
        WB: begin
          bus.reg_we     = 1'b1;
          bus.wb_sel     = (opcode == OP_LOAD);
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
        TRAP: begin
          bus.illegal = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  // Counters wrap naturally at 32 bits; TRAP cycles are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cycle_cnt   <= '0;
      bus.instret_cnt <= '0;
    end else begin
      if (state_q != TRAP) bus.cycle_cnt   <= bus.cycle_cnt + 32'd1;
      if (bus.instr_done)  bus.instret_cnt <= bus.instret_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.XLEN(32)) bus ();
  multicycle_ctrl #(.XLEN(32), .MEM_WAIT_MAX(0)) dut (.clk(clk), .reset(reset), .bus(bus));

  int compared = 0;
  int mismatched = 0;
  int step_no = 0;
  logic [15:0] exp_q[$];

  // {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b, alu_op, reg_we, wb_sel, instr_done, illegal}
  function automatic logic [15:0] mk(input logic [2:0] st, input logic req, input logic we,
      input logic asel, input logic irwe, input logic pcwe, input logic pcsrc, input logic srcb,
      input logic [1:0] aop, input logic regwe, input logic wbsel, input logic done, input logic ill);
    return {st, req, we, asel, irwe, pcwe, pcsrc, srcb, aop, regwe, wbsel, done, ill};
  endfunction

  logic [15:0] dut_vec;
  assign dut_vec = {bus.state_dbg, bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we,
                    bus.pc_we, bus.pc_src, bus.alu_src_b, bus.alu_op, bus.reg_we, bus.wb_sel,
                    bus.instr_done, bus.illegal};

  // Monitor: compare the cycle's expectation and the strobe-exclusivity rule.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      int mem_phase_req;
      e = exp_q.pop_front();
      compared++;
      if (dut_vec !== e) begin
        mismatched++;
        $display("FAIL outputs step %0d: got %h want %h", step_no, dut_vec, e);
      end
      mem_phase_req = (bus.mem_req === 1'b1 && bus.state_dbg === 3'd3) ? 1 : 0;
      compared++;
      if (int'(bus.ir_we === 1'b1) + int'(bus.reg_we === 1'b1) + mem_phase_req > 1) begin
        mismatched++;
        $display("FAIL exclusive_strobes step %0d: got ir_we=%b reg_we=%b mem_req=%b want at most one",
                 step_no, bus.ir_we, bus.reg_we, bus.mem_req);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] ins, input logic z, input logic rdy,
                      input logic [15:0] e);
    reset         = r;
    bus.instr     = ins;
    bus.alu_zero  = z;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BBAD = 32'h0020A463;
  localparam logic [31:0] I_BADO = 32'h0000007F;

  initial begin : stim
    logic [15:0] f_hit, f_wait, dec, zero, trapv;
    f_hit  = mk(3'd0, 1,0,0, 1,1,0, 0, 2'b00, 0,0,0,0);
    f_wait = mk(3'd0, 1,0,0, 0,0,0, 0, 2'b00, 0,0,0,0);
    dec    = mk(3'd1, 0,0,0, 0,0,0, 0, 2'b00, 0,0,0,0);
    zero   = 16'h0000;
    trapv  = mk(3'd5, 0,0,0, 0,0,0, 0, 2'b00, 0,0,0,1);

    reset = 1'b1; bus.instr = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    step(1, I_ADD, 0, 1, zero);
    step(1, I_ADD, 0, 1, zero);

    // R-type add, zero-wait
    step(0, I_ADD, 0, 1, f_hit);
    step(0, I_ADD, 0, 1, dec);
    step(0, I_ADD, 0, 1, mk(3'd2, 0,0,0, 0,0,0, 0, 2'b10, 0,0,0,0));
    step(0, I_ADD, 0, 1, mk(3'd4, 0,0,0, 0,0,0, 0, 2'b00, 1,0,1,0));

    // I-ALU addi with one fetch wait cycle
    step(0, I_ADDI, 0, 0, f_wait);
    step(0, I_ADDI, 0, 1, f_hit);
    step(0, I_ADDI, 0, 0, dec);
    step(0, I_ADDI, 0, 0, mk(3'd2, 0,0,0, 0,0,0, 1, 2'b10, 0,0,0,0));
    step(0, I_ADDI, 0, 0, mk(3'd4, 0,0,0, 0,0,0, 0, 2'b00, 1,0,1,0));

    // Load with 3 wait cycles in MEM: 8 cycles total
    step(0, I_LW, 0, 1, f_hit);
    step(0, I_LW, 0, 0, dec);
    step(0, I_LW, 0, 0, mk(3'd2, 0,0,0, 0,0,0, 1, 2'b00, 0,0,0,0));
    step(0, I_LW, 0, 0, mk(3'd3, 1,0,1, 0,0,0, 0, 2'b00, 0,0,0,0));
    step(0, I_LW, 0, 0, mk(3'd3, 1,0,1, 0,0,0, 0, 2'b00, 0,0,0,0));
    step(0, I_LW, 0, 0, mk(3'd3, 1,0,1, 0,0,0, 0, 2'b00, 0,0,0,0));
    step(0, I_LW, 0, 1, mk(3'd3, 1,0,1, 0,0,0, 0, 2'b00, 0,0,0,0));
    step(0, I_LW, 0, 0, mk(3'd4, 0,0,0, 0,0,0, 0, 2'b00, 1,1,1,0));

    // beq taken / not taken, bne taken / not taken
    step(0, I_BEQ, 1, 1, f_hit);
    step(0, I_BEQ, 1, 1, dec);
    step(0, I_BEQ, 1, 1, mk(3'd2, 0,0,0, 0,1,1, 0, 2'b01, 0,0,1,0));
    step(0, I_BEQ, 0, 1, f_hit);
    step(0, I_BEQ, 0, 1, dec);
    step(0, I_BEQ, 0, 1, mk(3'd2, 0,0,0, 0,0,0, 0, 2'b01, 0,0,1,0));
    step(0, I_BNE, 0, 1, f_hit);
    step(0, I_BNE, 0, 1, dec);
    step(0, I_BNE, 0, 1, mk(3'd2, 0,0,0, 0,1,1, 0, 2'b01, 0,0,1,0));
    step(0, I_BNE, 1, 1, f_hit);
    step(0, I_BNE, 1, 1, dec);
    step(0, I_BNE, 1, 1, mk(3'd2, 0,0,0, 0,0,0, 0, 2'b01, 0,0,1,0));

    // Store with one MEM wait cycle, no WB
    step(0, I_SW, 0, 1, f_hit);
    step(0, I_SW, 0, 1, dec);
    step(0, I_SW, 0, 1, mk(3'd2, 0,0,0, 0,0,0, 1, 2'b00, 0,0,0,0));
    step(0, I_SW, 0, 0, mk(3'd3, 1,1,1, 0,0,0, 0, 2'b00, 0,0,0,0));
    step(0, I_SW, 0, 1, mk(3'd3, 1,1,1, 0,0,0, 0, 2'b00, 0,0,1,0));
    step(0, I_ADD, 0, 0, f_wait);

    // Bad branch funct3 -> TRAP, sticky for 20 cycles, mem_ready ignored
    step(0, I_BBAD, 0, 1, f_hit);
    step(0, I_BBAD, 0, 1, dec);
    step(0, I_BBAD, 0, 1, mk(3'd2, 0,0,0, 0,0,0, 0, 2'b01, 0,0,0,0));
    for (int i = 0; i < 20; i++) step(0, I_BBAD, 0, 1, trapv);
    step(1, I_BBAD, 0, 1, zero);
    step(0, I_BADO, 0, 0, f_wait);

    // Unknown opcode -> TRAP from DECODE
    step(0, I_BADO, 0, 1, f_hit);
    step(0, I_BADO, 0, 1, dec);
    step(0, I_BADO, 0, 1, trapv);
    step(0, I_BADO, 0, 1, trapv);
    step(1, I_BADO, 0, 1, zero);
    step(0, I_ADD, 0, 1, f_hit);
    step(0, I_ADD, 0, 1, dec);
    step(0, I_ADD, 0, 1, mk(3'd2, 0,0,0, 0,0,0, 0, 2'b10, 0,0,0,0));
    step(0, I_ADD, 0, 1, mk(3'd4, 0,0,0, 0,0,0, 0, 2'b00, 1,0,1,0));

    // Reset while waiting in MEM abandons the access
    step(0, I_LW, 0, 1, f_hit);
    step(0, I_LW, 0, 0, dec);
    step(0, I_LW, 0, 0, mk(3'd2, 0,0,0, 0,0,0, 1, 2'b00, 0,0,0,0));
    step(0, I_LW, 0, 0, mk(3'd3, 1,0,1, 0,0,0, 0, 2'b00, 0,0,0,0));
    step(1, I_LW, 0, 0, zero);
`ifdef MULTICYCLE_CTRL_PERF_EN
    compared++;
    if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
      mismatched++;
      $display("FAIL perf_reset: got cycle=%0d instret=%0d want 0/0", bus.cycle_cnt, bus.instret_cnt);
    end
`endif
    step(0, I_LW, 0, 0, f_wait);
    step(0, I_LW, 0, 0, f_wait);

    @(negedge clk); #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
